uart_rx_bit_timer: RTL and testbench

Parametrised oversampling bit timer for the UART receiver. It counts clock edges per bit and bits per frame. It generates mid-bit sample strobes and delivers a (optionally majority-voted) sampled bit to the RX FSM and deserializer. Prescale and frame length are latched at frame start, and illegal configurations are flagged. It sits between the RX FSM (which drives `enable`) and the data sampler/deserializer.

---
 rtl/uart_rx_bit_timer.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_bit_timer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_rx_bit_timer
//
// Oversampling bit timer for the UART receiver. Counts clock edges per bit
// and bits per frame, emits a mid-bit sample strobe with the sampled line
// value, and pulses at every bit end and frame end. Prescale and frame
// length are latched when the RX FSM raises `enable`; an illegal latched
// configuration parks the timer in an error state until `enable` drops.
//
// Build option:
//   UART_RX_MAJORITY_EN  defined   -> sampled_bit is the 2-of-3 majority of
//                                     the samples at mid-1, mid and mid+1
//                        undefined -> only the mid sample is used
//
// Ports:
//   CLK           clock
//   RST           asynchronous active-low reset
//   enable        run request from the RX FSM; low clears the timer
//   Prescale      clock edges per bit, latched on enable rise (legal >= 3)
//   frame_bits    bits per frame, latched with Prescale (legal >= 1)
//   rx_in         synchronised serial input
//   edge_cnt      edge position within the current bit
//   bit_cnt       bit index within the frame
//   sample_valid  one-cycle pulse, sampled_bit has just been updated
//   sampled_bit   sampled bit value (idles high)
//   bit_done      one-cycle pulse at the end of each bit period
//   frame_done    one-cycle pulse at the end of the last bit of a frame
//   cfg_err       latched configuration is illegal
// ---------------------------------------------------------------------------
module uart_rx_bit_timer #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic [BIT_CNT_W-1:0]  frame_bits,
  input  logic                  rx_in,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sample_valid,
  output logic                  sampled_bit,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  cfg_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  localparam logic [PRESCALE_W-1:0] P_ZERO = '0;
  localparam logic [PRESCALE_W-1:0] P_ONE  = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] P_MIN  = PRESCALE_W'(3);
  localparam logic [BIT_CNT_W-1:0]  B_ZERO = '0;
  localparam logic [BIT_CNT_W-1:0]  B_ONE  = BIT_CNT_W'(1);

  logic [1:0]            state;
  logic [PRESCALE_W-1:0] p_q;
  logic [BIT_CNT_W-1:0]  f_q;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] edge_last;
  logic [BIT_CNT_W-1:0]  bit_last;
  logic                  running;
  logic                  s_mid;
  logic                  vote;

  // p_q >= 3 and f_q >= 1 whenever RUN is active, so neither subtraction
  // can wrap while the results are in use.
  assign mid       = p_q >> 1;
  assign edge_last = p_q - P_ONE;
  assign bit_last  = f_q - B_ONE;
  assign running   = enable && (state == RUN);

  // Mid sample capture. Reset to the idle line level so the first vote never
  // sees an undefined value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s_mid <= 1'b1;
    end else if (running && (edge_cnt == mid)) begin
      s_mid <= rx_in;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s_lo;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s_lo <= 1'b1;
    end else if (running && (edge_cnt == mid - P_ONE)) begin
      s_lo <= rx_in;
    end
  end

  // The mid+1 sample is rx_in itself on the strobe edge.
  assign vote = (s_lo & s_mid) | (s_lo & rx_in) | (s_mid & rx_in);
`else
  assign vote = s_mid;
`endif

  // NOTE: all state here is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others, independent of order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      p_q          <= P_ZERO;
      f_q          <= B_ZERO;
      edge_cnt     <= P_ZERO;
      bit_cnt      <= B_ZERO;
      sample_valid <= 1'b0;
      sampled_bit  <= 1'b1;
      bit_done     <= 1'b0;
      frame_done   <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      // Pulses default low; only RUN raises them for one cycle.
      bit_done     <= 1'b0;
      frame_done   <= 1'b0;
      sample_valid <= 1'b0;

      if (!enable) begin
        // Dropping enable wins over any bit end on the same edge.
        state    <= IDLE;
        edge_cnt <= P_ZERO;
        bit_cnt  <= B_ZERO;
        cfg_err  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            p_q      <= Prescale;
            f_q      <= frame_bits;
            edge_cnt <= P_ZERO;
            bit_cnt  <= B_ZERO;
            if ((Prescale < P_MIN) || (frame_bits == B_ZERO)) begin
              state   <= ERR;
              cfg_err <= 1'b1;
            end else begin
              state   <= RUN;
              cfg_err <= 1'b0;
            end
          end

          RUN: begin
            if (edge_cnt == edge_last) begin
              edge_cnt <= P_ZERO;
              bit_done <= 1'b1;
              if (bit_cnt == bit_last) begin
                bit_cnt    <= B_ZERO;
                frame_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + B_ONE;
              end
            end else begin
              edge_cnt <= edge_cnt + P_ONE;
            end

            // Strobe lands in the cycle where edge_cnt = mid+2 (or 0 of the
            // next bit when p_q = 3).
            if (edge_cnt == mid + P_ONE) begin
              sample_valid <= 1'b1;
              sampled_bit  <= vote;
            end
          end

          ERR: begin
            edge_cnt <= P_ZERO;
            bit_cnt  <= B_ZERO;
            cfg_err  <= 1'b1;
          end

          default: begin
            state    <= IDLE;
            edge_cnt <= P_ZERO;
            bit_cnt  <= B_ZERO;
            cfg_err  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_bit_timer
//
// Scoreboard bench for uart_rx_bit_timer. The driver applies one input set
// per clock, advances a reference model that works from "cycles since the
// configuration was latched" with plain modulo arithmetic, and pushes the
// expected per-cycle status and any expected pulse into queues. A monitor
// on the falling edge pops and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_uart_rx_bit_timer;

  localparam int PW = 6;
  localparam int BW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          enable;
  logic [PW-1:0] Prescale;
  logic [BW-1:0] frame_bits;
  logic          rx_in;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          sample_valid;
  logic          sampled_bit;
  logic          bit_done;
  logic          frame_done;
  logic          cfg_err;

  always #5 CLK = ~CLK;

  uart_rx_bit_timer #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .enable       (enable),
    .Prescale     (Prescale),
    .frame_bits   (frame_bits),
    .rx_in        (rx_in),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .sample_valid (sample_valid),
    .sampled_bit  (sampled_bit),
    .bit_done     (bit_done),
    .frame_done   (frame_done),
    .cfg_err      (cfg_err)
  );

  typedef struct {
    int stamp;
    int ec;
    int bc;
    bit cfg;
    bit sb;
  } st_exp_t;

  typedef struct {
    int stamp;
    bit bd;
    bit fd;
    bit sv;
    bit sb;
  } pulse_exp_t;

  st_exp_t    st_q[$];
  pulse_exp_t pl_q[$];

  int total  = 0;
  int bad    = 0;
  int drv_no = 0;
  int mon_no = 0;

  // Reference model: mode 0 idle, 1 running, 2 config error.
  int m_mode = 0;
  int m_n    = 0;
  int m_p    = 0;
  int m_f    = 1;
  bit m_sb   = 1'b1;
  bit hist[$];   // hist[k] = rx_in during the cycle k after the latch edge

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, mon_no, act, exp);
    end
  endtask

  // Apply inputs for the next rising edge, predict its outcome, then wait.
  task automatic step(input bit rst_v, input bit en, input int pre, input int fb, input bit rx);
    st_exp_t    s;
    pulse_exp_t pe;
    bit         fall;
    int         mid;
    int         ones;
    bit         bd;
    bit         fd;
    bit         sv;
    int         ec;
    int         bc;
    bit         cfg;

    fall       = (RST === 1'b1) && !rst_v;
    RST        = rst_v;
    enable     = en;
    Prescale   = PW'(pre);
    frame_bits = BW'(fb);
    rx_in      = rx;

    if (fall) begin
      #1;
      check("async_rst_edge_cnt",     int'(edge_cnt),     0);
      check("async_rst_bit_cnt",      int'(bit_cnt),      0);
      check("async_rst_sample_valid", int'(sample_valid), 0);
      check("async_rst_sampled_bit",  int'(sampled_bit),  1);
      check("async_rst_bit_done",     int'(bit_done),     0);
      check("async_rst_frame_done",   int'(frame_done),   0);
      check("async_rst_cfg_err",      int'(cfg_err),      0);
    end

    ec = 0; bc = 0; bd = 0; fd = 0; sv = 0; cfg = 0;
    if (!rst_v) begin
      m_mode = 0;
      m_sb   = 1'b1;
    end else if (!en) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_p = pre;
      m_f = fb;
      m_n = 0;
      hist.delete();
      if (pre < 3 || fb == 0) begin
        m_mode = 2;
        cfg    = 1'b1;
      end else begin
        m_mode = 1;
      end
    end else if (m_mode == 2) begin
      cfg = 1'b1;
    end else begin
      hist.push_back(rx);
      m_n++;
      mid = m_p / 2;
      ec  = m_n % m_p;
      bc  = (m_n / m_p) % m_f;
      bd  = (m_n % m_p) == 0;
      fd  = (m_n % (m_p * m_f)) == 0;
      if (m_n >= mid + 2 && ((m_n - mid - 2) % m_p) == 0) begin
        sv = 1'b1;
`ifdef UART_RX_MAJORITY_EN
        ones = int'(hist[m_n-3]) + int'(hist[m_n-2]) + int'(hist[m_n-1]);
        m_sb = (ones >= 2);
`else
        ones = 0;
        m_sb = hist[m_n-2];
`endif
      end
    end

    s.stamp = drv_no + 1;
    s.ec    = ec;
    s.bc    = bc;
    s.cfg   = cfg;
    s.sb    = m_sb;
    st_q.push_back(s);
    if (bd || fd || sv) begin
      pe.stamp = drv_no + 1;
      pe.bd    = bd;
      pe.fd    = fd;
      pe.sv    = sv;
      pe.sb    = m_sb;
      pl_q.push_back(pe);
    end

    @(negedge CLK);
    drv_no++;
    #2;
  endtask

  task automatic run_for(input int pre, input int fb, input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, pre, fb, 1'($urandom_range(0, 1)));
  endtask

  // Monitor: every falling edge compares status, and pulses when present
  // or expected.
  st_exp_t    ms;
  pulse_exp_t mp;

  always @(negedge CLK) begin
    mon_no++;
    if (st_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL state_queue cycle=%0d actual=empty expected=entry", mon_no);
    end else begin
      ms = st_q.pop_front();
      check("slot",        mon_no,            ms.stamp);
      check("edge_cnt",    int'(edge_cnt),    ms.ec);
      check("bit_cnt",     int'(bit_cnt),     ms.bc);
      check("cfg_err",     int'(cfg_err),     int'(ms.cfg));
      check("sampled_bit", int'(sampled_bit), int'(ms.sb));
    end

    if (pl_q.size() > 0 && pl_q[0].stamp == mon_no) begin
      mp = pl_q.pop_front();
      check("bit_done",     int'(bit_done),     int'(mp.bd));
      check("frame_done",   int'(frame_done),   int'(mp.fd));
      check("sample_valid", int'(sample_valid), int'(mp.sv));
      if (mp.sv) check("strobe_value", int'(sampled_bit), int'(mp.sb));
    end else begin
      check("no_pulse", int'({bit_done, frame_done, sample_valid}), 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", mon_no);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int pre;
    int fb;
    int len;
    int e;

    RST        = 1'b0;
    enable     = 1'b0;
    Prescale   = '0;
    frame_bits = '0;
    rx_in      = 1'b1;

    // Reset, then idle.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8, 10, 1'b1);

    // Full frame at Prescale 8, 10 bits.
    run_for(8, 10, 82);
    step(1'b1, 1'b0, 8, 10, 1'b1);

    // 0,1,0 around mid at edges 3,4,5; all other positions high.
    for (int i = 0; i < 20; i++) begin
      e = (m_mode == 1) ? (m_n % m_p) : -1;
      step(1'b1, 1'b1, 8, 10, !(e == 3 || e == 5));
    end
    step(1'b1, 1'b0, 8, 10, 1'b1);

    // Illegal configurations.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2, 10, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 2, 10, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8, 0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8, 0, 1'b1);

    // Boundary configurations.
    run_for(3, 1, 20);
    step(1'b1, 1'b0, 3, 1, 1'b1);
    run_for(3, 15, 50);
    step(1'b1, 1'b0, 3, 15, 1'b1);
    run_for(63, 2, 130);
    step(1'b1, 1'b0, 63, 2, 1'b1);

    // Prescale change mid-frame is ignored until enable toggles.
    run_for(8, 10, 20);
    run_for(16, 10, 30);
    step(1'b1, 1'b0, 16, 10, 1'b1);
    run_for(16, 10, 50);
    step(1'b1, 1'b0, 16, 10, 1'b1);

    // Enable dropped on a bit end.
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_mode == 1 && m_n >= 8 && (m_n % 8) == 7) begin
        found = 1'b1;
        break;
      end
      step(1'b1, 1'b1, 8, 10, 1'($urandom_range(0, 1)));
    end
    check("drop_point_reached", int'(found), 1);
    step(1'b1, 1'b0, 8, 10, 1'b1);
    step(1'b1, 1'b0, 8, 10, 1'b1);

    // Asynchronous reset in the middle of bit 5.
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_mode == 1 && ((m_n / 4) % 8) == 5 && (m_n % 4) == 2) begin
        found = 1'b1;
        break;
      end
      step(1'b1, 1'b1, 4, 8, 1'($urandom_range(0, 1)));
    end
    check("reset_point_reached", int'(found), 1);
    step(1'b0, 1'b1, 4, 8, 1'b0);
    step(1'b0, 1'b1, 4, 8, 1'b0);
    step(1'b1, 1'b0, 4, 8, 1'b1);

    // Randomised segments; configuration inputs wander during runs.
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 4))
        0:       pre = $urandom_range(0, 4);
        1:       pre = 63;
        default: pre = $urandom_range(3, 20);
      endcase
      fb  = $urandom_range(0, 15);
      len = $urandom_range(1, 150);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 15) == 0) pre = $urandom_range(0, 63);
        step(1'b1, 1'b1, pre, fb, 1'($urandom_range(0, 1)));
      end
      len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) step(1'b1, 1'b0, pre, fb, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8, 10, 1'b1);
    check("queues_drained", st_q.size() + pl_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
